// File: rtl/fc3_classifier_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : fc3_classifier_if
// Brief   : Control, memory-read and score-write signals of fc3_classifier.
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
interface fc3_classifier_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         start;
  logic                         busy;
  logic [6:0]                   act_addr;
  logic signed [DATA_WIDTH-1:0] act_data;
  logic [9:0]                   w_addr;
  logic signed [DATA_WIDTH-1:0] w_data;
  logic [3:0]                   bias_addr;
  logic signed [DATA_WIDTH-1:0] bias_data;
  logic                         score_we;
  logic [3:0]                   score_addr;
  logic signed [DATA_WIDTH-1:0] score_data;
  logic [3:0]                   class_id;
  logic                         done;

  modport slave (
    input  start, act_data, w_data, bias_data,
    output busy, act_addr, w_addr, bias_addr,
           score_we, score_addr, score_data, class_id, done
  );

  modport master (
    output start, act_data, w_data, bias_data,
    input  busy, act_addr, w_addr, bias_addr,
           score_we, score_addr, score_data, class_id, done
  );
endinterface
`default_nettype wire

// File: rtl/fc3_classifier.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : fc3_classifier
// Brief   : LeNet-5 84->10 fully-connected output layer with argmax, one MAC.
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
module fc3_classifier #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int IN_N       = 84,
  parameter int OUT_N      = 10,
  parameter int ACC_WIDTH  = 32
) (
  input  logic            clk,
  input  logic            rst,
  fc3_classifier_if.slave bus
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [6:0] LAST_K = 7'(IN_N - 1);
  localparam logic [3:0] LAST_C = 4'(OUT_N - 1);
  localparam logic signed [DATA_WIDTH-1:0] SCORE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] SCORE_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MAC   = 3'd1,
    S_FLUSH = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                       state_q, state_d;
  logic [6:0]                   k_q, k_d;
  logic [3:0]                   class_q, class_d;
  logic                         flush_q, flush_d;
  logic                         rd_vld_q, rd_vld_d;
  logic                         prod_vld_q, prod_vld_d;
  logic signed [PW-1:0]         prod_q, prod_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0] max_q, max_d;
  logic [3:0]                   cand_q, cand_d;
  logic [3:0]                   class_id_q, class_id_d;

  logic signed [ACC_WIDTH-1:0]  prod_term_w;
  logic signed [ACC_WIDTH:0]    sum_w;
  logic signed [DATA_WIDTH-1:0] score_w;

  // One extra bit on the sum so acc + bias can never wrap before clamping.
  always_comb begin
    prod_term_w = ACC_WIDTH'(prod_q >>> FRAC_BITS);
    sum_w = {acc_q[ACC_WIDTH-1], acc_q}
          + {{(ACC_WIDTH-DATA_WIDTH+1){bus.bias_data[DATA_WIDTH-1]}}, bus.bias_data};
    if (sum_w[ACC_WIDTH:DATA_WIDTH-1] == {(ACC_WIDTH-DATA_WIDTH+2){sum_w[ACC_WIDTH]}}) begin
      score_w = sum_w[DATA_WIDTH-1:0];
    end else if (sum_w[ACC_WIDTH]) begin
      score_w = SCORE_MIN;
    end else begin
      score_w = SCORE_MAX;
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    class_d    = class_q;
    flush_d    = flush_q;
    acc_d      = acc_q;
    max_d      = max_q;
    cand_d     = cand_q;
    class_id_d = class_id_q;
    // Two-stage valid pipe: address issued -> read data -> registered product.
    rd_vld_d   = (state_q == S_MAC);
    prod_vld_d = rd_vld_q;
    prod_d     = PW'(bus.act_data) * PW'(bus.w_data);
    if (prod_vld_q) begin
      acc_d = acc_q + prod_term_w;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_MAC;
          k_d     = '0;
          class_d = '0;
          acc_d   = '0;
          max_d   = SCORE_MIN;
          cand_d  = '0;
        end
      end
      S_MAC: begin
        if (k_q == LAST_K) begin
          k_d     = '0;
          flush_d = 1'b0;
          state_d = S_FLUSH;
        end else begin
          k_d = k_q + 7'd1;
        end
      end
      S_FLUSH: begin
        if (flush_q) begin
          state_d = S_WRITE;
        end else begin
          flush_d = 1'b1;
        end
      end
      S_WRITE: begin
        acc_d = '0;
        // Strict compare keeps the lower class index on ties.
        if (score_w > max_q) begin
          max_d  = score_w;
          cand_d = class_q;
        end
        if (class_q == LAST_C) begin
          class_d = '0;
          state_d = S_DONE;
        end else begin
          class_d = class_q + 4'd1;
          state_d = S_MAC;
        end
      end
      S_DONE: begin
        class_id_d = cand_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      class_q    <= '0;
      flush_q    <= 1'b0;
      rd_vld_q   <= 1'b0;
      prod_vld_q <= 1'b0;
      prod_q     <= '0;
      acc_q      <= '0;
      max_q      <= SCORE_MIN;
      cand_q     <= '0;
      class_id_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      class_q    <= class_d;
      flush_q    <= flush_d;
      rd_vld_q   <= rd_vld_d;
      prod_vld_q <= prod_vld_d;
      prod_q     <= prod_d;
      acc_q      <= acc_d;
      max_q      <= max_d;
      cand_q     <= cand_d;
      class_id_q <= class_id_d;
    end
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.act_addr   = k_q;
  assign bus.w_addr     = 10'(class_q) * 10'(IN_N) + 10'(k_q);
  assign bus.bias_addr  = class_q;
  assign bus.score_we   = (state_q == S_WRITE);
  assign bus.score_addr = class_q;
  assign bus.score_data = (state_q == S_WRITE) ? score_w : '0;
  // The winner is presented during the done pulse, then held in class_id_q.
  assign bus.class_id   = (state_q == S_DONE) ? cand_q : class_id_q;

endmodule
`default_nettype wire

// File: tb/tb_fc3_classifier.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_fc3_classifier
// Brief   : Randomized self-checking bench for fc3_classifier with a score model.
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
module tb_fc3_classifier;

  localparam int IN_N  = 84;
  localparam int OUT_N = 10;
  localparam int CLS_CYC = IN_N + 3;
  localparam int DONE_CYC = CLS_CYC * OUT_N + 1;

  logic clk;
  logic rst;

  fc3_classifier_if #(.DATA_WIDTH(16)) ifc ();

  fc3_classifier #(
    .DATA_WIDTH(16), .FRAC_BITS(8), .IN_N(IN_N), .OUT_N(OUT_N), .ACC_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic signed [15:0] act_mem [IN_N];
  logic signed [15:0] w_mem   [IN_N*OUT_N];
  logic signed [15:0] b_mem   [OUT_N];

  // Synchronous-read memories, one cycle of latency.
  always @(posedge clk) begin
    ifc.act_data  <= act_mem[int'(ifc.act_addr)];
    ifc.w_data    <= w_mem[int'(ifc.w_addr)];
    ifc.bias_data <= b_mem[int'(ifc.bias_addr)];
  end

  int n_checks = 0;
  int n_pass   = 0;
  int exp_sc [OUT_N];
  int exp_cls;
  int obs_sc [OUT_N];
  int obs_cls;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic signed [15:0] rnd(input int mag);
    int r;
    r = int'($urandom_range(2 * mag)) - mag;
    return 16'(r);
  endfunction

  // Scores from the layer definition: sum of per-product arithmetic shifts,
  // plus bias, clamped to 16 bits; argmax with strict compare from -32768.
  function automatic void compute_model();
    longint acc;
    longint best;
    best = -32768;
    exp_cls = 0;
    for (int c = 0; c < OUT_N; c++) begin
      acc = 0;
      for (int k = 0; k < IN_N; k++) begin
        acc += (longint'(act_mem[k]) * longint'(w_mem[c*IN_N + k])) >>> 8;
      end
      acc += longint'(b_mem[c]);
      if (acc > 32767) acc = 32767;
      if (acc < -32768) acc = -32768;
      exp_sc[c] = int'(acc);
      if (acc > best) begin
        best = acc;
        exp_cls = c;
      end
    end
  endfunction

  task automatic fill_random(input int mag);
    for (int k = 0; k < IN_N; k++) act_mem[k] = rnd(mag);
    for (int i = 0; i < IN_N*OUT_N; i++) w_mem[i] = rnd(mag);
    for (int c = 0; c < OUT_N; c++) b_mem[c] = rnd(mag);
  endtask

  // Called at a negedge with the DUT idle. inject pulses start mid-run and in
  // the done cycle; both must be ignored.
  task automatic run_check(input string tag, input bit inject);
    int cyc, cls, rel, done_cyc, addr_err, busy_err, we_err, post_err;
    int wr_addr[$];
    int wr_data[$];
    compute_model();
    done_cyc = -1; addr_err = 0; busy_err = 0; we_err = 0; post_err = 0;
    obs_cls = -1;
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    cyc = 1;
    while (done_cyc < 0 && cyc <= 1000) begin
      if (cyc < DONE_CYC) begin
        cls = (cyc - 1) / CLS_CYC;
        rel = (cyc - 1) % CLS_CYC;
        if (rel < IN_N && (int'(ifc.w_addr) != cls*IN_N + rel || int'(ifc.act_addr) != rel))
          addr_err++;
        if (int'(ifc.bias_addr) != cls) addr_err++;
      end
      if (!ifc.busy) busy_err++;
      if (ifc.score_we) begin
        wr_addr.push_back(int'(ifc.score_addr));
        wr_data.push_back(int'($signed(ifc.score_data)));
        if (cyc != CLS_CYC * wr_addr.size()) we_err++;
      end
      if (ifc.done) begin
        done_cyc = cyc;
        obs_cls = int'(ifc.class_id);
      end
      ifc.start = inject && (cyc == 300 || ifc.done);
      if (done_cyc < 0) begin
        @(negedge clk);
        cyc++;
      end
    end
    @(negedge clk);
    ifc.start = 1'b0;
    check({tag, ".busy_after"}, int'(ifc.busy), 0);
    check({tag, ".done_after"}, int'(ifc.done), 0);
    check({tag, ".class_held"}, int'(ifc.class_id), exp_cls);
    repeat (5) begin
      @(negedge clk);
      if (ifc.busy || ifc.score_we || ifc.done) post_err++;
    end
    check({tag, ".done_cycle"}, done_cyc, DONE_CYC);
    check({tag, ".n_writes"}, wr_addr.size(), OUT_N);
    for (int i = 0; i < wr_addr.size() && i < OUT_N; i++) begin
      obs_sc[i] = wr_data[i];
      check($sformatf("%s.addr%0d", tag, i), wr_addr[i], i);
      check($sformatf("%s.score%0d", tag, i), wr_data[i], exp_sc[i]);
    end
    check({tag, ".class_id"}, obs_cls, exp_cls);
    check({tag, ".addr_seq_err"}, addr_err, 0);
    check({tag, ".busy_err"}, busy_err, 0);
    check({tag, ".we_timing_err"}, we_err, 0);
    check({tag, ".idle_after_err"}, post_err, 0);
  endtask

  task automatic abort_with_reset();
    int cyc, err;
    fill_random(512);
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    cyc = 1;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("rst.busy_before", int'(ifc.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst.busy", int'(ifc.busy), 0);
    check("rst.score_we", int'(ifc.score_we), 0);
    check("rst.class_id", int'(ifc.class_id), 0);
    rst = 1'b0;
    err = 0;
    repeat (600) begin
      @(negedge clk);
      if (ifc.busy || ifc.score_we || ifc.done) err++;
    end
    check("rst.quiet_after", err, 0);
  endtask

  initial begin
    rst = 1'b1;
    ifc.start = 1'b0;
    for (int k = 0; k < IN_N; k++) act_mem[k] = '0;
    for (int i = 0; i < IN_N*OUT_N; i++) w_mem[i] = '0;
    for (int c = 0; c < OUT_N; c++) b_mem[c] = '0;
    repeat (3) @(negedge clk);
    check("reset.busy", int'(ifc.busy), 0);
    check("reset.act_addr", int'(ifc.act_addr), 0);
    check("reset.w_addr", int'(ifc.w_addr), 0);
    check("reset.bias_addr", int'(ifc.bias_addr), 0);
    check("reset.score_we", int'(ifc.score_we), 0);
    check("reset.score_addr", int'(ifc.score_addr), 0);
    check("reset.score_data", int'(ifc.score_data), 0);
    check("reset.class_id", int'(ifc.class_id), 0);
    check("reset.done", int'(ifc.done), 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic: activations 1.0, weight class c = c+1 LSBs, zero bias.
    for (int k = 0; k < IN_N; k++) act_mem[k] = 16'h0100;
    for (int c = 0; c < OUT_N; c++) begin
      b_mem[c] = '0;
      for (int k = 0; k < IN_N; k++) w_mem[c*IN_N + k] = 16'(c + 1);
    end
    run_check("basic", 1'b0);
    check("basic.class9", obs_cls, 9);
    check("basic.score0", obs_sc[0], 84);

    // Random Q8.8 values within +/-2.0.
    for (int r = 0; r < 3; r++) begin
      fill_random(512);
      run_check($sformatf("rand%0d", r), 1'b0);
    end

    // Positive saturation on class 3.
    fill_random(4);
    for (int k = 0; k < IN_N; k++) begin
      act_mem[k] = 16'h7FFF;
      w_mem[3*IN_N + k] = 16'h7FFF;
    end
    for (int c = 0; c < OUT_N; c++) b_mem[c] = '0;
    run_check("satpos", 1'b0);
    check("satpos.score3", obs_sc[3], 32767);
    check("satpos.class3", obs_cls, 3);

    // Negative saturation on class 3.
    for (int k = 0; k < IN_N; k++) w_mem[3*IN_N + k] = 16'sh8001;
    run_check("satneg", 1'b0);
    check("satneg.score3", obs_sc[3], -32768);

    // Tie between classes 2 and 7.
    for (int k = 0; k < IN_N; k++) act_mem[k] = 16'h0100;
    for (int c = 0; c < OUT_N; c++) begin
      b_mem[c] = '0;
      for (int k = 0; k < IN_N; k++)
        w_mem[c*IN_N + k] = (c == 2 || c == 7) ? 16'h0100 : rnd(64);
    end
    run_check("tie", 1'b0);
    check("tie.class2", obs_cls, 2);

    // Stray starts during the run and in the done cycle.
    fill_random(512);
    run_check("protocol", 1'b1);

    // Mid-run reset, then a fresh run.
    abort_with_reset();
    fill_random(512);
    run_check("after_rst", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
